// File: rtl/vtdet_sync_analyzer.sv
// vtdet_sync_analyzer: measures incoming hsync/vsync/de timing, recovers pixel
// coordinates and line/frame strobes, and flags lock once frames repeat identically.
module vtdet_sync_analyzer #(
    parameter int CW          = 10,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vid_hsync,
    input  logic          vid_vsync,
    input  logic          vid_de,
    output logic [CW-1:0] disp_x,
    output logic [CW-1:0] disp_y,
    output logic          disp_active,
    output logic          line_end,
    output logic          frame_end,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] v_active,
    output logic          locked
);
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    state_t        state, state_nx;
    logic [3:0]    mcnt, mcnt_nx, mcnt_inc;
    logic          hs_r, vs_r, de_r;
    logic          hs_in, vs_in;
    logic          hs_edge, vs_edge, de_rise, de_fall;
    logic [CW-1:0] hcnt, pcnt, lcnt, acnt, hcnt_inc;
    logic [CW-1:0] st_h, st_a, st_v, st_va;
    logic [CW-1:0] nt_h, nt_a;
    logic          frame_match, line_bad;

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + CW'(1);
    endfunction

    // Edges compare the live input against its registered copy, so every
    // registered result appears exactly one clock after the input changes.
    assign hs_in   = (vid_hsync == SYNC_POL);
    assign vs_in   = (vid_vsync == SYNC_POL);
    assign hs_edge = hs_in & ~hs_r;
    assign vs_edge = vs_in & ~vs_r;
    assign de_rise = vid_de & ~de_r;
    assign de_fall = ~vid_de & de_r;

    assign hcnt_inc = inc(hcnt);
    assign nt_h     = hs_edge ? hcnt_inc : h_total;
    assign nt_a     = de_fall ? pcnt : h_active;
    assign mcnt_inc = mcnt + 4'd1;
    assign locked   = (state == LOCKED);

    assign frame_match = ({nt_h, nt_a, lcnt, acnt} == {st_h, st_a, st_v, st_va}) &&
                         (|nt_h) && (|nt_a) && (|lcnt) && (|acnt);
    assign line_bad    = (hs_edge && hcnt_inc != st_h) || (hcnt == CMAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_r        <= 1'b0;
            vs_r        <= 1'b0;
            de_r        <= 1'b0;
            hcnt        <= '0;
            pcnt        <= '0;
            lcnt        <= '0;
            acnt        <= '0;
            h_total     <= '0;
            h_active    <= '0;
            v_total     <= '0;
            v_active    <= '0;
            disp_x      <= '0;
            disp_y      <= '0;
            disp_active <= 1'b0;
            line_end    <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            hs_r        <= hs_in;
            vs_r        <= vs_in;
            de_r        <= vid_de;
            hcnt        <= hs_edge ? '0 : hcnt_inc;
            h_total     <= nt_h;
            pcnt        <= de_fall ? '0 : vid_de ? inc(pcnt) : pcnt;
            h_active    <= nt_a;
            // A sync edge coinciding with vsync is line 1 of the new frame.
            lcnt        <= vs_edge ? (hs_edge ? CW'(1) : '0) : hs_edge ? inc(lcnt) : lcnt;
            acnt        <= vs_edge ? '0 : de_rise ? inc(acnt) : acnt;
            v_total     <= vs_edge ? lcnt : v_total;
            v_active    <= vs_edge ? acnt : v_active;
            disp_x      <= de_rise ? '0 : vid_de ? inc(disp_x) : disp_x;
            disp_y      <= de_rise ? ((acnt == '0) ? '0 : inc(disp_y)) : disp_y;
            disp_active <= vid_de;
            line_end    <= de_fall;
            frame_end   <= vs_edge;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= UNLOCKED;
            mcnt  <= '0;
            st_h  <= '0;
            st_a  <= '0;
            st_v  <= '0;
            st_va <= '0;
        end else begin
            state <= state_nx;
            mcnt  <= mcnt_nx;
            if (vs_edge) begin
                st_h  <= nt_h;
                st_a  <= nt_a;
                st_v  <= lcnt;
                st_va <= acnt;
            end
        end
    end

    always_comb begin
        state_nx = state;
        mcnt_nx  = mcnt;
        if (state == UNLOCKED) begin
            if (vs_edge) begin
                mcnt_nx  = frame_match ? mcnt_inc : '0;
                state_nx = (frame_match && mcnt_inc >= 4'(LOCK_FRAMES)) ? LOCKED : UNLOCKED;
            end
        end else if ((vs_edge && !frame_match) || line_bad) begin
            state_nx = UNLOCKED;
            mcnt_nx  = '0;
        end
    end
endmodule

// File: tb/tb_vtdet_sync_analyzer.sv
// tb_vtdet_sync_analyzer: scoreboard bench on a reduced 20x10 raster (12x6 active);
// two instances run the same stream with opposite sync polarity.
module tb_vtdet_sync_analyzer;
    localparam int CW   = 10;
    localparam int HT   = 20;
    localparam int HA   = 12;
    localparam int VT   = 10;
    localparam int VA   = 6;
    localparam int HSW  = 3;
    localparam int VSW  = 2;
    localparam int DE0  = 5;
    localparam int DE1  = DE0 + HA;
    localparam int VA0  = 3;

    typedef struct {int ht; int ha; int vt; int va; int lk; bit dc;} frame_t;
    typedef struct {int x; int y;} line_t;

    logic          clk = 1'b0, reset_n = 1'b0, hs_a = 1'b0, vs_a = 1'b0, de = 1'b0;
    logic [CW-1:0] disp_x[2], disp_y[2], h_total[2], h_active[2], v_total[2], v_active[2];
    logic          disp_active[2], line_end[2], frame_end[2], locked[2];

    frame_t fq[$];
    line_t  lq[$];
    int     vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    vtdet_sync_analyzer #(.CW(CW), .SYNC_POL(1'b0), .LOCK_FRAMES(2)) u0 (
        .clk(clk), .reset_n(reset_n), .vid_hsync(~hs_a), .vid_vsync(~vs_a), .vid_de(de),
        .disp_x(disp_x[0]), .disp_y(disp_y[0]), .disp_active(disp_active[0]),
        .line_end(line_end[0]), .frame_end(frame_end[0]), .h_total(h_total[0]),
        .h_active(h_active[0]), .v_total(v_total[0]), .v_active(v_active[0]), .locked(locked[0]));

    vtdet_sync_analyzer #(.CW(CW), .SYNC_POL(1'b1), .LOCK_FRAMES(2)) u1 (
        .clk(clk), .reset_n(reset_n), .vid_hsync(hs_a), .vid_vsync(vs_a), .vid_de(de),
        .disp_x(disp_x[1]), .disp_y(disp_y[1]), .disp_active(disp_active[1]),
        .line_end(line_end[1]), .frame_end(frame_end[1]), .h_total(h_total[1]),
        .h_active(h_active[1]), .v_total(v_total[1]), .v_active(v_active[1]), .locked(locked[1]));

    function automatic void chk(input string n, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endfunction

    task automatic chk_zero(input string n);
        for (int d = 0; d < 2; d++)
            chk($sformatf("%s_nonzero_d%0d", n, d),
                longint'({disp_x[d], disp_y[d], h_total[d], h_active[d], v_total[d], v_active[d],
                          disp_active[d], line_end[d], frame_end[d], locked[d]} !== '0), 0);
    endtask

    task automatic step(input bit h, input bit v, input bit e);
        @(negedge clk);
        hs_a = h;
        vs_a = v;
        de   = e;
    endtask

    // Pushes the record expected at this frame's opening vsync edge, then drives the frame.
    task automatic frame(input int ht, input int ha, input int vt, input int va, input int lk,
                         input bit dc, input int short_line, input int short_len,
                         input int fall_line, input int stop_line);
        frame_t f;
        line_t  ln;
        f.ht = ht; f.ha = ha; f.vt = vt; f.va = va; f.lk = lk; f.dc = dc;
        fq.push_back(f);
        for (int l = 0; l < VT; l++) begin
            int len;
            bit act;
            len = (l == short_line) ? short_len : HT;
            act = (l >= VA0) && (l < VA0 + VA);
            for (int c = 0; c < len; c++) begin
                if (l == stop_line && c == 8) return;
                if (act && c == DE1) begin
                    ln.x = HA - 1;
                    ln.y = l - VA0;
                    lq.push_back(ln);
                end
                step(c < HSW, l < VSW, act && c >= DE0 && c < DE1);
                if (l == fall_line && c < 2)
                    for (int d = 0; d < 2; d++)
                        chk($sformatf("lock_at_short_hs_d%0d_c%0d", d, c), locked[d], (c == 0) ? 1 : 0);
            end
        end
    endtask

    always @(posedge clk) begin
        frame_t f;
        line_t  ln;
        #1;
        if (frame_end[0] || frame_end[1]) begin
            if (fq.size() == 0) chk("frame_end_unexpected", 1, 0);
            else begin
                f = fq.pop_front();
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("frame_end_d%0d", d), frame_end[d], 1);
                    if (!f.dc) chk($sformatf("h_total_d%0d", d), h_total[d], f.ht);
                    chk($sformatf("h_active_d%0d", d), h_active[d], f.ha);
                    chk($sformatf("v_total_d%0d", d), v_total[d], f.vt);
                    chk($sformatf("v_active_d%0d", d), v_active[d], f.va);
                    chk($sformatf("locked_d%0d", d), locked[d], f.lk);
                end
            end
        end
        if (line_end[0] || line_end[1]) begin
            if (lq.size() == 0) chk("line_end_unexpected", 1, 0);
            else begin
                ln = lq.pop_front();
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("line_end_d%0d", d), line_end[d], 1);
                    chk($sformatf("disp_x_d%0d", d), disp_x[d], ln.x);
                    chk($sformatf("disp_y_d%0d", d), disp_y[d], ln.y);
                    chk($sformatf("line_h_active_d%0d", d), h_active[d], HA);
                    chk($sformatf("disp_active_d%0d", d), disp_active[d], 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        reset_n = 1'b1;
        repeat (3) step(0, 0, 0);
        // Lock acquisition: the third complete frame's end locks.
        frame(0, 0, 0, 0, 0, 1, -1, 0, -1, -1);
        frame(HT, HA, VT, VA, 0, 0, -1, 0, -1, -1);
        frame(HT, HA, VT, VA, 0, 0, -1, 0, -1, -1);
        frame(HT, HA, VT, VA, 1, 0, -1, 0, -1, -1);
        // Mid-frame 19-clock line drops lock at the following hs edge.
        frame(HT, HA, VT, VA, 1, 0, 4, HT - 1, 5, -1);
        frame(HT, HA, VT, VA, 0, 0, -1, 0, -1, -1);
        frame(HT, HA, VT, VA, 1, 0, 9, HT - 1, -1, -1);
        // Short last line is reported in the tuple and costs three clean frames.
        frame(HT - 1, HA, VT, VA, 0, 0, -1, 0, -1, -1);
        frame(HT, HA, VT, VA, 0, 0, -1, 0, -1, -1);
        frame(HT, HA, VT, VA, 0, 0, -1, 0, -1, -1);
        frame(HT, HA, VT, VA, 1, 0, -1, 0, -1, -1);
        // One more hs pulse, then hsync stops: lock must hold until hcnt saturates.
        for (int k = 0; k <= 1030; k++) begin
            step(k < HSW, 0, 0);
            if (k == 1020) for (int d = 0; d < 2; d++) chk($sformatf("lock_before_timeout_d%0d", d), locked[d], 1);
            if (k == 1030) for (int d = 0; d < 2; d++) chk($sformatf("lock_after_timeout_d%0d", d), locked[d], 0);
        end
        frame((1 << CW) - 1, HA, VT + 1, VA, 0, 0, -1, 0, -1, -1);
        frame(HT, HA, VT, VA, 0, 0, -1, 0, -1, -1);
        frame(HT, HA, VT, VA, 0, 0, -1, 0, -1, 4);
        #2;
        reset_n = 1'b0;
        hs_a = 1'b0;
        vs_a = 1'b0;
        de   = 1'b0;
        #1;
        chk_zero("async_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step(0, 0, 0);
        frame(0, 0, 0, 0, 0, 1, -1, 0, -1, -1);
        frame(HT, HA, VT, VA, 0, 0, -1, 0, -1, -1);
        frame(HT, HA, VT, VA, 0, 0, -1, 0, -1, -1);
        frame(HT, HA, VT, VA, 1, 0, -1, 0, -1, -1);
        frame(HT, HA, VT, VA, 1, 0, -1, 0, -1, -1);
        repeat (5) step(0, 0, 0);
        chk("frame_queue_drained", fq.size(), 0);
        chk("line_queue_drained", lq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
